// File: rtl/tile_wb_packer.sv
// Transmit-side tile packer: snapshots a systolic result tile and serialises it
// into AXI write-data beats, row- or column-major, 32-bit or FP16 packed.
package params;
  typedef enum logic [1:0] {FP32 = 2'd0, FP16 = 2'd1, INT8 = 2'd2, INT4 = 2'd3} type_t;
endpackage

// Per-lane element selector; the top stitches lanes into the beat layout.
module tile_wb_lane #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = 32,
  parameter int KW   = 3,
  parameter int J    = 0
) (
  input  logic [ROWS-1:0][COLS-1:0][DW-1:0] tile_i,
  input  logic [KW-1:0]                     k_i,
  input  logic                              col_major_i,
  output logic [DW-1:0]                     e32_o,
  output logic [15:0]                       lo16_o,
  output logic [15:0]                       hi16_o
);
  logic [KW-1:0] k2, k2p1;

  // FP16 beats pair rows/cols 2k and 2k+1; k never exceeds ROWS/2-1 there.
  assign k2   = {k_i[KW-2:0], 1'b0};
  assign k2p1 = {k_i[KW-2:0], 1'b1};

  always_comb begin
    if (col_major_i) begin
      e32_o  = tile_i[J][k_i];
      lo16_o = tile_i[J][k2][15:0];
      hi16_o = tile_i[J][k2p1][15:0];
    end else begin
      e32_o  = tile_i[k_i][J];
      lo16_o = tile_i[k2][J][15:0];
      hi16_o = tile_i[k2p1][J][15:0];
    end
  end
endmodule

module tile_wb_packer #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DW    = 32,
  parameter int BUS_W = 256
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              tile_valid,
  output logic                              tile_ready,
  input  logic [ROWS-1:0][COLS-1:0][DW-1:0] tile_data,
  input  params::type_t                     data_type,
  input  logic                              col_major,
  output logic                              wvalid,
  input  logic                              wready,
  output logic [BUS_W-1:0]                  wdata,
  output logic [BUS_W/8-1:0]                wstrb,
  output logic                              wlast,
  output logic [4:0]                        burst_num,
  output logic                              busy
);
  localparam int KW = $clog2(ROWS);
  localparam logic [KW-1:0] LAST32 = KW'(ROWS - 1);
  localparam logic [KW-1:0] LAST16 = KW'(ROWS / 2 - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                            state_q, state_d;
  logic [KW-1:0]                     beat_q, beat_d;
  logic [ROWS-1:0][COLS-1:0][DW-1:0] tile_q;
  logic                              fp16_q, colm_q;
  logic                              cap, last_beat;

  logic [COLS-1:0][DW-1:0] w32;
  logic [COLS-1:0][15:0]   lo16, hi16;
  logic [BUS_W-1:0]        beat_pk;

  assign tile_ready = rst_n && (state_q == IDLE);
  assign cap        = tile_valid && tile_ready;
  assign busy       = (state_q == SEND);
  assign last_beat  = (beat_q == (fp16_q ? LAST16 : LAST32));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (tile_valid) state_d = SEND;
      end
      SEND: begin
        if (wready) begin
          if (last_beat) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Tile payload is only meaningful in SEND, so it carries no reset.
  always_ff @(posedge clk) begin
    if (cap) begin
      tile_q <= tile_data;
      fp16_q <= (data_type == params::FP16);
      colm_q <= col_major;
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_lane
    tile_wb_lane #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .KW(KW), .J(j)) u_lane (
      .tile_i     (tile_q),
      .k_i        (beat_q),
      .col_major_i(colm_q),
      .e32_o      (w32[j]),
      .lo16_o     (lo16[j]),
      .hi16_o     (hi16[j])
    );
  end

  assign beat_pk   = fp16_q ? {hi16, lo16} : w32;
  assign wvalid    = busy;
  assign wdata     = busy ? beat_pk : '0;
  assign wstrb     = {(BUS_W/8){busy}};
  assign wlast     = busy && last_beat;
  assign burst_num = 5'(beat_q);
endmodule

// File: tb/tb_tile_wb_packer.sv
// Directed bench for tile_wb_packer: reset, FP32/FP16 packing, stalls,
// back-to-back capture and mid-tile reset.
module tb_tile_wb_packer;
  typedef logic [7:0][7:0][31:0] tile_t;

  logic          clk = 1'b0;
  logic          rst_n, tile_valid, col_major, wready;
  tile_t         tile_data;
  params::type_t data_type;
  logic          tile_ready, wvalid, wlast, busy;
  logic [255:0]  wdata;
  logic [31:0]   wstrb;
  logic [4:0]    burst_num;

  int n_chk  = 0;
  int n_pass = 0;

  tile_wb_packer dut (
    .clk(clk), .rst_n(rst_n), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_data(tile_data), .data_type(data_type), .col_major(col_major),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .burst_num(burst_num), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic tile_t mk(input logic [15:0] base, input logic [15:0] hi);
    tile_t t;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        t[r][c] = {hi, 16'(base + 16'(16 * r + c))};
    return t;
  endfunction

  function automatic logic [255:0] exp_beat(input tile_t t, input bit fp16, input bit col, input int k);
    logic [255:0] e;
    e = '0;
    for (int j = 0; j < 8; j++) begin
      if (!fp16) begin
        e[32*j +: 32] = col ? t[j][k] : t[k][j];
      end else begin
        e[16*j +: 16]       = col ? t[j][2*k][15:0]   : t[2*k][j][15:0];
        e[128+16*j +: 16]   = col ? t[j][2*k+1][15:0] : t[2*k+1][j][15:0];
      end
    end
    return e;
  endfunction

  task automatic start(input tile_t t, input params::type_t dt, input bit col);
    tile_data  = t;
    data_type  = dt;
    col_major  = col;
    tile_valid = 1'b1;
    step();
    tile_valid = 1'b0;
  endtask

  // Expects beat 0 on the bus now, wready=1; drains and checks the idle cycle.
  task automatic drain(input string nm, input tile_t t, input bit fp16, input bit col);
    int nb;
    nb = fp16 ? 4 : 8;
    for (int k = 0; k < nb; k++) begin
      chk({nm, "_wvalid"}, 256'(wvalid), 256'(1));
      chk({nm, "_burst"}, 256'(burst_num), 256'(k));
      chk({nm, "_wlast"}, 256'(wlast), 256'(k == nb - 1));
      chk({nm, "_wstrb"}, 256'(wstrb), 256'(32'hFFFF_FFFF));
      chk({nm, "_wdata"}, wdata, exp_beat(t, fp16, col, k));
      step();
    end
    chk({nm, "_end_wvalid"}, 256'(wvalid), 256'(0));
    chk({nm, "_end_busy"}, 256'(busy), 256'(0));
    chk({nm, "_end_ready"}, 256'(tile_ready), 256'(1));
    chk({nm, "_end_burst"}, 256'(burst_num), 256'(0));
  endtask

  initial begin
    tile_t ta, tb, td;
    logic [255:0] e;
    int pat[11] = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1};
    int idx;

    ta = mk(16'h0000, 16'h0000);
    tb = mk(16'h0100, 16'h0000);
    td = mk(16'h0000, 16'hDEAD);

    // 1: reset with tile_valid asserted
    rst_n = 1'b0; tile_valid = 1'b1; wready = 1'b1; col_major = 1'b0;
    data_type = params::FP32; tile_data = ta;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ready", 256'(tile_ready), 256'(0));
      chk("rst_wvalid", 256'(wvalid), 256'(0));
      chk("rst_wdata", wdata, 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
    end
    rst_n = 1'b1; tile_valid = 1'b0;
    #1;
    chk("rel_ready", 256'(tile_ready), 256'(1));
    chk("rel_wstrb", 256'(wstrb), 256'(0));
    chk("rel_burst", 256'(burst_num), 256'(0));
    step();
    chk("rel_idle", 256'(wvalid), 256'(0));

    // 2: FP32 row-major, lane j of beat k = 16k+j
    start(ta, params::FP32, 1'b0);
    for (int k = 0; k < 8; k++) begin
      e = '0;
      for (int j = 0; j < 8; j++) e[32*j +: 32] = 32'(16 * k + j);
      chk("t2_wdata", wdata, e);
      chk("t2_burst", 256'(burst_num), 256'(k));
      chk("t2_wlast", 256'(wlast), 256'(k == 7));
      chk("t2_wstrb", 256'(wstrb), 256'(32'hFFFF_FFFF));
      chk("t2_ready", 256'(tile_ready), 256'(0));
      step();
    end
    chk("t2_end_wvalid", 256'(wvalid), 256'(0));
    chk("t2_end_ready", 256'(tile_ready), 256'(1));

    // 3: FP16 column-major, upper halves must be dropped
    start(td, params::FP16, 1'b1);
    step();
    chk("t3_b1_lo3", 256'(wdata[48 +: 16]), 256'(16'h0032));
    chk("t3_b1_hi3", 256'(wdata[176 +: 16]), 256'(16'h0033));
    for (int j = 0; j < 16; j++)
      chk("t3_nodead", 256'(wdata[16*j +: 16] == 16'hDEAD), 256'(0));
    // re-run the whole tile from beat 0 after this one drains
    for (int k = 1; k < 4; k++) step();
    chk("t3_idle", 256'(wvalid), 256'(0));
    start(td, params::FP16, 1'b1);
    drain("t3", td, 1'b1, 1'b1);

    // 4: FP32 with stalls
    start(ta, params::FP32, 1'b0);
    idx = 0;
    for (int i = 0; i < 11; i++) begin
      wready = pat[i][0];
      chk("t4_wvalid", 256'(wvalid), 256'(1));
      chk("t4_burst", 256'(burst_num), 256'(idx));
      chk("t4_wdata", wdata, exp_beat(ta, 1'b0, 1'b0, idx));
      chk("t4_wlast", 256'(wlast), 256'(idx == 7));
      if (pat[i] != 0) idx++;
      step();
    end
    wready = 1'b1;
    chk("t4_end_wvalid", 256'(wvalid), 256'(0));
    chk("t4_end_busy", 256'(busy), 256'(0));

    // 5: tile_valid held through SEND with new data
    tile_data = ta; data_type = params::FP32; col_major = 1'b0; tile_valid = 1'b1;
    step();
    tile_data = tb;
    for (int k = 0; k < 8; k++) begin
      chk("t5a_wdata", wdata, exp_beat(ta, 1'b0, 1'b0, k));
      chk("t5a_ready", 256'(tile_ready), 256'(0));
      step();
    end
    chk("t5_gap_wvalid", 256'(wvalid), 256'(0));
    chk("t5_gap_ready", 256'(tile_ready), 256'(1));
    step();
    tile_valid = 1'b0;
    drain("t5b", tb, 1'b0, 1'b0);

    // 6: reset right after beat 3 transfers
    start(ta, params::FP32, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("t6_burst", 256'(burst_num), 256'(k));
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_rst_wvalid", 256'(wvalid), 256'(0));
    chk("t6_rst_busy", 256'(busy), 256'(0));
    chk("t6_rst_burst", 256'(burst_num), 256'(0));
    start(ta, params::FP16, 1'b0);
    drain("t6", ta, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
